// File: rtl/sdram_pixel_write_buffer.sv
// Show-ahead FIFO that queues pixel writes (SDRAM address + data) and drains them
// to the SDRAM controller write port with a valid/waitrequest handshake.
module sdram_pixel_write_buffer #(
   parameter int HADDR_WIDTH = 20,
   parameter int DATA_WIDTH  = 16,
   parameter int DEPTH_LOG2  = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [HADDR_WIDTH-1:0] in_addr,
   input  logic [DATA_WIDTH-1:0]  in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [HADDR_WIDTH-1:0] sdram_addr,
   output logic [DATA_WIDTH-1:0]  sdram_wrdata,
   output logic                   sdram_write,
   input  logic                   sdram_waitrequest,
   output logic [DEPTH_LOG2:0]    level,
   output logic                   idle,
   output logic [15:0]            write_count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int ENTRY_WIDTH = HADDR_WIDTH + DATA_WIDTH;
   localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   LEVEL_ONE  = (DEPTH_LOG2+1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);

   logic [ENTRY_WIDTH-1:0] mem [DEPTH];

   logic [DEPTH_LOG2-1:0] wrPtr_q, wrPtr_d;
   logic [DEPTH_LOG2-1:0] rdPtr_q, rdPtr_d;
   logic [DEPTH_LOG2:0]   level_q, level_d;
   logic [15:0]           writeCount_q, writeCount_d;

   logic                   push;
   logic                   pop;
   logic [ENTRY_WIDTH-1:0] headEntry;

   // in_ready looks only at the registered level, so a full buffer never accepts
   // a new entry even if the controller is draining one in the same cycle.
   always_comb begin
      in_ready     = !rst && (level_q < FULL_LEVEL);
      sdram_write  = (level_q != '0);
      push         = in_valid && in_ready;
      pop          = sdram_write && !sdram_waitrequest;
      headEntry    = mem[rdPtr_q];
      sdram_addr   = '0;
      sdram_wrdata = '0;
      if (sdram_write) begin
         sdram_addr   = headEntry[ENTRY_WIDTH-1:DATA_WIDTH];
         sdram_wrdata = headEntry[DATA_WIDTH-1:0];
      end
      level       = level_q;
      idle        = (level_q == '0);
      write_count = writeCount_q;
   end

   always_comb begin
      wrPtr_d      = wrPtr_q;
      rdPtr_d      = rdPtr_q;
      level_d      = level_q;
      writeCount_d = writeCount_q;
      if (push) begin
         wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (pop) begin
         rdPtr_d      = rdPtr_q + PTR_ONE;
         writeCount_d = writeCount_q + 16'd1;
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LEVEL_ONE;
         2'b01:   level_d = level_q - LEVEL_ONE;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wrPtr_q      <= '0;
         rdPtr_q      <= '0;
         level_q      <= '0;
         writeCount_q <= '0;
      end else begin
         wrPtr_q      <= wrPtr_d;
         rdPtr_q      <= rdPtr_d;
         level_q      <= level_d;
         writeCount_q <= writeCount_d;
      end
   end

   // Storage carries no reset; stale contents are never visible because level gates the output.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wrPtr_q] <= {in_addr, in_data};
      end
   end

endmodule

// File: tb/tb_sdram_pixel_write_buffer.sv
// Directed bench for sdram_pixel_write_buffer: single write, fill, stall,
// concurrent push/pop across pointer wrap, mid-run reset and write_count wrap.
module tb_sdram_pixel_write_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [19:0] in_addr;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [19:0] sdram_addr;
   logic [15:0] sdram_wrdata;
   logic        sdram_write;
   logic        sdram_waitrequest;
   logic [3:0]  level;
   logic        idle;
   logic [15:0] write_count;

   int testsRun  = 0;
   int failCount = 0;

   sdram_pixel_write_buffer #(
      .HADDR_WIDTH(20),
      .DATA_WIDTH (16),
      .DEPTH_LOG2 (3)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .in_addr          (in_addr),
      .in_data          (in_data),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .sdram_addr       (sdram_addr),
      .sdram_wrdata     (sdram_wrdata),
      .sdram_write      (sdram_write),
      .sdram_waitrequest(sdram_waitrequest),
      .level            (level),
      .idle             (idle),
      .write_count      (write_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun++;
      assert (observed === expected)
      else begin
         failCount++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [19:0] addr,
                                input logic [15:0] data);
      in_valid = valid;
      in_addr  = addr;
      in_data  = data;
   endtask

   initial begin
      rst = 1'b1;
      sdram_waitrequest = 1'b0;
      applyStimulus(1'b0, 20'h0, 16'h0);
      tick();
      tick();
      checkOutput("rst_in_ready", in_ready, 0);
      checkOutput("rst_idle", idle, 1);
      checkOutput("rst_write", sdram_write, 0);
      checkOutput("rst_level", level, 0);
      checkOutput("rst_count", write_count, 0);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_ready", in_ready, 1);

      // Single write
      applyStimulus(1'b1, 20'h40281, 16'hF800);
      tick();
      applyStimulus(1'b0, 20'h0, 16'h0);
      checkOutput("single_write", sdram_write, 1);
      checkOutput("single_addr", sdram_addr, 32'h40281);
      checkOutput("single_data", sdram_wrdata, 32'hF800);
      checkOutput("single_level", level, 1);
      tick();
      checkOutput("single_done_write", sdram_write, 0);
      checkOutput("single_done_addr", sdram_addr, 0);
      checkOutput("single_done_level", level, 0);
      checkOutput("single_done_idle", idle, 1);
      checkOutput("single_done_count", write_count, 1);

      // Fill under stall, then drain
      sdram_waitrequest = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         applyStimulus(1'b1, 20'h10000 + 20'(i), 16'(i));
         tick();
      end
      checkOutput("fill_level", level, 8);
      checkOutput("fill_ready", in_ready, 0);
      applyStimulus(1'b1, 20'h10009, 16'h0009);
      tick();
      checkOutput("fill_ninth_level", level, 8);
      checkOutput("fill_head", sdram_wrdata, 1);
      applyStimulus(1'b0, 20'h0, 16'h0);
      sdram_waitrequest = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         checkOutput("drain_write", sdram_write, 1);
         checkOutput("drain_data", sdram_wrdata, 32'(i));
         checkOutput("drain_addr", sdram_addr, 32'h10000 + 32'(i));
         tick();
      end
      checkOutput("drain_level", level, 0);
      checkOutput("drain_count", write_count, 9);

      // Stall stability
      sdram_waitrequest = 1'b1;
      applyStimulus(1'b1, 20'h55555, 16'hABCD);
      tick();
      applyStimulus(1'b0, 20'h0, 16'h0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall_write", sdram_write, 1);
         checkOutput("stall_addr", sdram_addr, 32'h55555);
         checkOutput("stall_data", sdram_wrdata, 32'hABCD);
         checkOutput("stall_count", write_count, 9);
         tick();
      end
      sdram_waitrequest = 1'b0;
      tick();
      checkOutput("stall_done_write", sdram_write, 0);
      checkOutput("stall_done_count", write_count, 10);

      // Simultaneous push/pop at level 3 across pointer wrap
      sdram_waitrequest = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 20'h20100 + 20'(i), 16'h0100 + 16'(i));
         tick();
      end
      checkOutput("pp_level_init", level, 3);
      sdram_waitrequest = 1'b0;
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b1, 20'h20103 + 20'(k), 16'h0103 + 16'(k));
         #1;
         checkOutput("pp_order_data", sdram_wrdata, 32'h0100 + 32'(k));
         checkOutput("pp_order_addr", sdram_addr, 32'h20100 + 32'(k));
         tick();
         checkOutput("pp_level", level, 3);
      end
      applyStimulus(1'b0, 20'h0, 16'h0);
      for (int k = 20; k < 23; k++) begin
         checkOutput("pp_tail_data", sdram_wrdata, 32'h0100 + 32'(k));
         tick();
      end
      checkOutput("pp_idle", idle, 1);
      checkOutput("pp_count", write_count, 33);

      // Reset mid-operation
      sdram_waitrequest = 1'b1;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 20'h30000 + 20'(i), 16'h0200 + 16'(i));
         tick();
      end
      checkOutput("mid_level", level, 5);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_ready", in_ready, 0);
      tick();
      rst = 1'b0;
      applyStimulus(1'b0, 20'h0, 16'h0);
      sdram_waitrequest = 1'b0;
      #1;
      checkOutput("mid_after_level", level, 0);
      checkOutput("mid_after_write", sdram_write, 0);
      checkOutput("mid_after_count", write_count, 0);
      checkOutput("mid_after_ready", in_ready, 1);
      tick();
      checkOutput("mid_no_stale_write", sdram_write, 0);
      checkOutput("mid_no_stale_count", write_count, 0);

      // write_count wrap: 65536 back-to-back pushes, all drained
      for (int k = 0; k < 65536; k++) begin
         applyStimulus(1'b1, 20'(k), 16'(k));
         tick();
      end
      applyStimulus(1'b0, 20'h0, 16'h0);
      #1;
      checkOutput("wrap_pre_count", write_count, 32'hFFFF);
      checkOutput("wrap_pre_level", level, 1);
      checkOutput("wrap_head_data", sdram_wrdata, 32'hFFFF);
      checkOutput("wrap_head_addr", sdram_addr, 32'h0FFFF);
      tick();
      checkOutput("wrap_count", write_count, 0);
      checkOutput("wrap_idle", idle, 1);
      applyStimulus(1'b1, 20'hABCDE, 16'h1234);
      tick();
      applyStimulus(1'b0, 20'h0, 16'h0);
      checkOutput("wrap_path_addr", sdram_addr, 32'hABCDE);
      checkOutput("wrap_path_data", sdram_wrdata, 32'h1234);
      tick();
      checkOutput("wrap_path_count", write_count, 1);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
